// File: rtl/ez8_pkg.sv
// Shared command codes, status bit positions and FSM states for the ez8 host sequencer.
package ez8_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_HALT = 8'h03;

    localparam int unsigned ST_DONE = 0;
    localparam int unsigned ST_ERR  = 1;
    localparam int unsigned ST_HALT = 2;

    typedef enum logic [3:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        RST,
        RUN,
        RESP0,
        RESP1
    } state_e;

    function automatic logic [7:0] mk_status(input logic halt, input logic err);
        logic [7:0] s;
        s          = '0;
        s[ST_DONE] = 1'b1;
        s[ST_ERR]  = err;
        s[ST_HALT] = halt;
        return s;
    endfunction

endpackage

// File: rtl/ez8_host_ctrl.sv
// Host-side sequencer for the ez8 CPU: loads program words, runs the CPU under a watchdog
// and returns a two-byte status response. All outputs are registered.
module ez8_host_ctrl
    import ez8_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TIMEOUT_W   = 24,
    parameter int unsigned RUN_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              resp_valid,
    output logic [7:0]        resp_data,
    input  logic              resp_ready,
    output logic              cpu_reset,
    output logic              cpu_pause,
    output logic [ADDR_W-1:0] instr_writeaddr,
    output logic [DATA_W-1:0] instr_writedata,
    output logic              instr_write_en,
    input  logic              cpu_stopped,
    input  logic              cpu_error,
    input  logic [7:0]        cpu_accum,
    output logic              busy
);

    state_e                 state_q, state_d;
    logic [7:0]             len_hi_q, len_hi_d;
    logic [ADDR_W-1:0]      last_q, last_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic [7:0]             hi_q, hi_d;
    logic                   rst_cnt_q, rst_cnt_d;
    logic [TIMEOUT_W-1:0]   wd_q, wd_d;
    logic [7:0]             acc_q, acc_d;

    logic                   in_ready_q, in_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [7:0]             resp_data_q, resp_data_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic                   cpu_pause_q, cpu_pause_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;
    logic                   wr_en_q, wr_en_d;
    logic                   busy_q, busy_d;

    logic                   accept;
    logic                   resp_hs;
    logic                   halt_hit;
    logic                   timeout_hit;

    assign accept      = in_valid && in_ready_q;
    assign resp_hs     = resp_valid_q && resp_ready;
    assign halt_hit    = accept && (in_data == CMD_HALT);
    assign timeout_hit = (RUN_TIMEOUT != 0) && (wd_q == TIMEOUT_W'(RUN_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        rst_cnt_d   = rst_cnt_q;
        wd_d        = wd_q;
        acc_d       = acc_q;
        resp_data_d = resp_data_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_data == CMD_LOAD) begin
                        state_d = LEN_HI;
                    end else if (in_data == CMD_RUN) begin
                        state_d   = RST;
                        rst_cnt_d = 1'b0;
                        wd_d      = '0;
                    end
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_hi_d = in_data;
                    state_d  = LEN_LO;
                end
            end
            LEN_LO: begin
                // A zero length wraps to the all-ones last index, i.e. the full memory.
                if (accept) begin
                    last_d  = ADDR_W'({len_hi_q, in_data}) - 1'b1;
                    cnt_d   = '0;
                    state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_d    = in_data;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = DATA_W'({hi_q, in_data});
                    if (cnt_q == last_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = DATA_HI;
                    end
                end
            end
            RST: begin
                if (rst_cnt_q) state_d = RUN;
                else           rst_cnt_d = 1'b1;
            end
            RUN: begin
                wd_d = wd_q + 1'b1;
                if (cpu_stopped || cpu_error) begin
                    state_d     = RESP0;
                    resp_data_d = mk_status(1'b0, cpu_error);
                    acc_d       = cpu_accum;
                end else if (halt_hit) begin
                    state_d     = RESP0;
                    resp_data_d = mk_status(1'b1, 1'b0);
                    acc_d       = cpu_accum;
                end else if (timeout_hit) begin
                    state_d     = RESP0;
                    resp_data_d = mk_status(1'b1, 1'b1);
                    acc_d       = cpu_accum;
                end
            end
            RESP0: begin
                if (resp_hs) begin
                    state_d     = RESP1;
                    resp_data_d = acc_q;
                end
            end
            RESP1: begin
                if (resp_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs are derived from the next state so they line up with it.
        in_ready_d   = !(state_d inside {RST, RESP0, RESP1});
        resp_valid_d = (state_d inside {RESP0, RESP1});
        cpu_reset_d  = (state_d == RST);
        cpu_pause_d  = (state_d != RUN);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            len_hi_q     <= '0;
            last_q       <= '0;
            cnt_q        <= '0;
            hi_q         <= '0;
            rst_cnt_q    <= 1'b0;
            wd_q         <= '0;
            acc_q        <= '0;
            in_ready_q   <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            cpu_reset_q  <= 1'b0;
            cpu_pause_q  <= 1'b1;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            rst_cnt_q    <= rst_cnt_d;
            wd_q         <= wd_d;
            acc_q        <= acc_d;
            in_ready_q   <= in_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            cpu_reset_q  <= cpu_reset_d;
            cpu_pause_q  <= cpu_pause_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign cpu_reset       = cpu_reset_q;
    assign cpu_pause       = cpu_pause_q;
    assign instr_writeaddr = wr_addr_q;
    assign instr_writedata = wr_data_q;
    assign instr_write_en  = wr_en_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_ez8_host_ctrl.sv
// Directed bench for ez8_host_ctrl: scoreboards for memory writes and response bytes.
module tb_ez8_host_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        resp_ready;
    logic        cpu_reset;
    logic        cpu_pause;
    logic [11:0] instr_writeaddr;
    logic [15:0] instr_writedata;
    logic        instr_write_en;
    logic        cpu_stopped;
    logic        cpu_error;
    logic [7:0]  cpu_accum;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_wr  = 0;
    logic [11:0] last_wr_addr = '0;
    logic [31:0] exp_wr[$];
    logic [31:0] exp_resp[$];

    ez8_host_ctrl #(
        .ADDR_W     (12),
        .DATA_W     (16),
        .TIMEOUT_W  (24),
        .RUN_TIMEOUT(100)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_ready     (resp_ready),
        .cpu_reset      (cpu_reset),
        .cpu_pause      (cpu_pause),
        .instr_writeaddr(instr_writeaddr),
        .instr_writedata(instr_writedata),
        .instr_write_en (instr_write_en),
        .cpu_stopped    (cpu_stopped),
        .cpu_error      (cpu_error),
        .cpu_accum      (cpu_accum),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 100 && !accepted; i++) begin
            if (in_ready) accepted = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!accepted) check("send_accept", {31'd0, accepted}, 32'd1);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready",   {31'd0, in_ready},       32'd1);
        check("rst_resp_valid", {31'd0, resp_valid},     32'd0);
        check("rst_cpu_reset",  {31'd0, cpu_reset},      32'd0);
        check("rst_cpu_pause",  {31'd0, cpu_pause},      32'd1);
        check("rst_write_en",   {31'd0, instr_write_en}, 32'd0);
        check("rst_addr",       {20'd0, instr_writeaddr}, 32'd0);
        check("rst_data",       {16'd0, instr_writedata}, 32'd0);
        check("rst_busy",       {31'd0, busy},           32'd0);
    endtask

    task automatic drain_resp(input int bound);
        for (int i = 0; i < bound && (exp_resp.size() != 0 || resp_valid); i++) tick();
        check("resp_drained", exp_resp.size(), 32'd0);
        check("resp_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    always @(negedge clk) begin : wr_mon
        logic [31:0] e;
        if (!reset && instr_write_en) begin
            e = (exp_wr.size() != 0) ? exp_wr.pop_front() : 32'hFFFF_FFFF;
            check("write", {4'h0, instr_writeaddr, instr_writedata}, e);
            n_wr++;
            last_wr_addr = instr_writeaddr;
        end
    end

    always @(negedge clk) begin : resp_mon
        logic [31:0] e;
        if (!reset && resp_valid && resp_ready) begin
            e = (exp_resp.size() != 0) ? exp_resp.pop_front() : 32'h0000_0100;
            check("resp_byte", {24'd0, resp_data}, e);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish required finish");
        $fatal(1);
    end

    initial begin
        int base;
        logic [15:0] w;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        resp_ready  = 1'b1;
        cpu_stopped = 1'b0;
        cpu_error   = 1'b0;
        cpu_accum   = '0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_values();

        // 1: three-word load.
        exp_wr.push_back({4'h0, 12'h000, 16'h1234});
        exp_wr.push_back({4'h0, 12'h001, 16'hABCD});
        exp_wr.push_back({4'h0, 12'h002, 16'h0001});
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB);
        send_byte(8'hCD); send_byte(8'h00); send_byte(8'h01);
        check("l3_write_en_last", {31'd0, instr_write_en}, 32'd1);
        check("l3_busy_after", {31'd0, busy}, 32'd0);
        tick(); tick();
        check("l3_count", n_wr, 32'd3);
        check("l3_queue", exp_wr.size(), 32'd0);

        // 2: zero length means the full 4096-word memory.
        base = n_wr;
        for (int i = 0; i < 4096; i++) begin
            w = 16'(i * 7 + 16'h0301);
            exp_wr.push_back({4'h0, 12'(i), w});
        end
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        for (int i = 0; i < 4096; i++) begin
            w = 16'(i * 7 + 16'h0301);
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        check("full_busy_after", {31'd0, busy}, 32'd0);
        repeat (5) tick();
        check("full_count", n_wr - base, 32'd4096);
        check("full_last_addr", {20'd0, last_wr_addr}, 32'h0000_0FFF);
        check("full_queue", exp_wr.size(), 32'd0);

        // 3: run, CPU stops 10 cycles in with accum 0x5A.
        exp_resp.push_back(32'h01);
        exp_resp.push_back(32'h5A);
        send_byte(8'h02);
        check("run_rst_c1", {31'd0, cpu_reset}, 32'd1);
        check("run_rst_pause_c1", {31'd0, cpu_pause}, 32'd1);
        check("run_rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("run_rst_c2", {31'd0, cpu_reset}, 32'd1);
        tick();
        check("run_rst_done", {31'd0, cpu_reset}, 32'd0);
        check("run_pause_low", {31'd0, cpu_pause}, 32'd0);
        repeat (9) tick();
        check("run_pause_low_c10", {31'd0, cpu_pause}, 32'd0);
        cpu_stopped = 1'b1;
        cpu_accum   = 8'h5A;
        tick();
        cpu_stopped = 1'b0;
        check("stop_pause_high", {31'd0, cpu_pause}, 32'd1);
        check("stop_resp_valid", {31'd0, resp_valid}, 32'd1);
        tick();
        cpu_accum = 8'h00;
        drain_resp(50);

        // 4: error and HALT in the same cycle; error takes precedence.
        exp_resp.push_back(32'h03);
        exp_resp.push_back(32'h3C);
        cpu_accum = 8'h3C;
        send_byte(8'h02);
        repeat (2) tick();
        repeat (3) tick();
        check("eh_in_ready_run", {31'd0, in_ready}, 32'd1);
        cpu_error = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h03;
        tick();
        cpu_error = 1'b0;
        in_valid  = 1'b0;
        check("eh_pause_high", {31'd0, cpu_pause}, 32'd1);
        drain_resp(50);

        // 5: watchdog expiry with a stalled response consumer.
        exp_resp.push_back(32'h07);
        exp_resp.push_back(32'h77);
        cpu_accum  = 8'h77;
        resp_ready = 1'b0;
        send_byte(8'h02);
        repeat (2) tick();
        check("wd_pause_c1", {31'd0, cpu_pause}, 32'd0);
        repeat (99) tick();
        check("wd_pause_c100", {31'd0, cpu_pause}, 32'd0);
        tick();
        check("wd_pause_c101", {31'd0, cpu_pause}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            check("wd_hold_valid", {31'd0, resp_valid}, 32'd1);
            check("wd_hold_data", {24'd0, resp_data}, 32'h07);
            tick();
        end
        resp_ready = 1'b1;
        drain_resp(50);

        // 6: reset in the middle of a load, then a fresh load restarts at address 0.
        exp_wr.push_back({4'h0, 12'h000, 16'h1122});
        exp_wr.push_back({4'h0, 12'h001, 16'h3344});
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values();
        exp_wr.push_back({4'h0, 12'h000, 16'hBEEF});
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hBE); send_byte(8'hEF);
        tick(); tick();
        check("reload_queue", exp_wr.size(), 32'd0);
        check("reload_busy", {31'd0, busy}, 32'd0);
        check("resp_queue_end", exp_resp.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
